// File: rtl/uart_traffic_gen_chk_if.sv
// uart_traffic_gen_chk_if
//   Groups the user-side Uart_Driver signals that the traffic
//   generator/checker drives and observes.
//   tx_data/tx_valid : generator -> Uart_Driver i_user_tx_data/valid
//   tx_ready         : Uart_Driver o_user_tx_ready -> generator
//   rx_data/rx_valid : Uart_Driver o_user_rx_data/valid -> checker
//   master modport is the generator/checker; slave modport is the UART side.
interface uart_traffic_gen_chk_if #(
  parameter int unsigned P_DATA_WIDTH = 8
);
  logic [P_DATA_WIDTH-1:0] tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic [P_DATA_WIDTH-1:0] rx_data;
  logic                    rx_valid;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );
endinterface

// File: rtl/uart_traffic_gen_chk.sv
// uart_traffic_gen_chk
//   Stimulus generator and receive checker for the Uart_Driver user
//   interface. Sends a selectable pattern (incrementing, PRBS, fixed,
//   walking-one) and checks received data against an independent copy of
//   the same generator. Reports tx, rx and error counts.
// Ports
//   clk, w_user_rst     clock and asynchronous active-high reset
//   i_start / i_stop    run control pulses
//   i_mode / i_seed     pattern select and first value, sampled on i_start
//   uart (master)       tx_data/tx_valid/tx_ready, rx_data/rx_valid
//   o_busy              run in progress
//   o_done / o_timeout  sticky completion flags, cleared by i_start
//   o_tx_count          frames accepted
//   o_rx_count          frames received while busy
//   o_err_count         rx mismatches
//   o_first_err_data    rx data of the first mismatch in the run
module uart_traffic_gen_chk #(
  parameter int unsigned             P_DATA_WIDTH    = 8,
  parameter int unsigned             P_FRAME_COUNT   = 256,
  parameter int unsigned             P_GAP_CYCLES    = 0,
  parameter logic [P_DATA_WIDTH-1:0] P_LFSR_TAPS     = 'hB8,
  parameter int unsigned             P_CNT_WIDTH     = 16,
  parameter int unsigned             P_DRAIN_TIMEOUT = 100000
) (
  input  logic                    clk,
  input  logic                    w_user_rst,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic [1:0]              i_mode,
  input  logic [P_DATA_WIDTH-1:0] i_seed,
  uart_traffic_gen_chk_if.master  uart,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_timeout,
  output logic [P_CNT_WIDTH-1:0]  o_tx_count,
  output logic [P_CNT_WIDTH-1:0]  o_rx_count,
  output logic [P_CNT_WIDTH-1:0]  o_err_count,
  output logic [P_DATA_WIDTH-1:0] o_first_err_data
);

  localparam int unsigned W  = P_DATA_WIDTH;
  localparam int unsigned CW = P_CNT_WIDTH;

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] FRAME_LAST =
    CW'((P_FRAME_COUNT == 0) ? 0 : P_FRAME_COUNT - 1);
  localparam logic          CONTINUOUS = (P_FRAME_COUNT == 0);
  localparam logic          HAS_GAP    = (P_GAP_CYCLES != 0);
  localparam logic [31:0]   GAP_LAST   =
    (P_GAP_CYCLES == 0) ? 32'd0 : 32'(P_GAP_CYCLES - 1);
  localparam logic [31:0]   TO_LAST    =
    (P_DRAIN_TIMEOUT == 0) ? 32'd0 : 32'(P_DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    MODE_INC,
    MODE_PRBS,
    MODE_FIXED,
    MODE_WALK
  } mode_e;

  function automatic logic [W-1:0] f_first(input mode_e mode,
                                           input logic [W-1:0] seed);
    case (mode)
      MODE_INC:   return seed;
      MODE_PRBS:  return (seed == '0) ? W'(1) : seed;
      MODE_FIXED: return seed;
      default:    return W'(1);
    endcase
  endfunction

  function automatic logic [W-1:0] f_next(input mode_e mode,
                                          input logic [W-1:0] v);
    case (mode)
      MODE_INC:   return v + W'(1);
      MODE_PRBS:  return v[0] ? ((v >> 1) ^ P_LFSR_TAPS) : (v >> 1);
      MODE_FIXED: return v;
      default:    return {v[W-2:0], v[W-1]};
    endcase
  endfunction

  function automatic logic [CW-1:0] f_sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  state_e         state_q, state_d;
  mode_e          mode_q, mode_d;
  logic [W-1:0]   tx_pat_q, tx_pat_d;
  logic [W-1:0]   rx_pat_q, rx_pat_d;
  logic [CW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [CW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [CW-1:0]  err_cnt_q, err_cnt_d;
  logic [W-1:0]   first_err_q, first_err_d;
  logic           done_q, done_d;
  logic           timeout_q, timeout_d;
  logic           stop_q, stop_d;
  logic [31:0]    gap_q, gap_d;
  logic [31:0]    to_q, to_d;

  logic           tx_valid;
  logic           accept;
  logic           rx_beat;
  logic           last_frame;

  assign tx_valid   = (state_q == S_SEND);
  assign accept     = tx_valid & uart.tx_ready;
  assign rx_beat    = uart.rx_valid & (state_q != S_IDLE);
  assign last_frame = !CONTINUOUS && (tx_cnt_q == FRAME_LAST);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    tx_pat_d    = tx_pat_q;
    rx_pat_d    = rx_pat_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    stop_d      = stop_q;
    gap_d       = gap_q;
    to_d        = to_q;

    // Checker runs in every non-idle state, independent of the tx side.
    if (rx_beat) begin
      rx_cnt_d = f_sat_inc(rx_cnt_q);
      rx_pat_d = f_next(mode_q, rx_pat_q);
      if (uart.rx_data != rx_pat_q) begin
        err_cnt_d = f_sat_inc(err_cnt_q);
        if (err_cnt_q == '0) begin
          first_err_d = uart.rx_data;
        end
      end
    end

    if (accept) begin
      tx_cnt_d = f_sat_inc(tx_cnt_q);
      tx_pat_d = f_next(mode_q, tx_pat_q);
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d     = S_SEND;
          mode_d      = mode_e'(i_mode);
          tx_pat_d    = f_first(mode_e'(i_mode), i_seed);
          rx_pat_d    = f_first(mode_e'(i_mode), i_seed);
          tx_cnt_d    = '0;
          rx_cnt_d    = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
          done_d      = 1'b0;
          timeout_d   = 1'b0;
          stop_d      = 1'b0;
        end
      end
      S_SEND: begin
        // A stop seen while a frame is pending is remembered so that the
        // frame still completes before draining.
        if (i_stop) begin
          stop_d = 1'b1;
        end
        if (accept) begin
          if (last_frame || stop_q || i_stop) begin
            state_d = S_DRAIN;
            to_d    = '0;
          end else if (HAS_GAP) begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end
      end
      S_GAP: begin
        if (i_stop) begin
          state_d = S_DRAIN;
          to_d    = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_SEND;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      S_DRAIN: begin
        if (rx_cnt_q == tx_cnt_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (rx_beat) begin
          to_d = '0;
        end else if (to_q == TO_LAST) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          to_d = to_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge w_user_rst) begin
    if (w_user_rst) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_INC;
      tx_pat_q    <= '0;
      rx_pat_q    <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      stop_q      <= 1'b0;
      gap_q       <= '0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      tx_pat_q    <= tx_pat_d;
      rx_pat_q    <= rx_pat_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      stop_q      <= stop_d;
      gap_q       <= gap_d;
      to_q        <= to_d;
    end
  end

  assign uart.tx_data     = tx_pat_q;
  assign uart.tx_valid    = tx_valid;
  assign o_busy           = (state_q != S_IDLE);
  assign o_done           = done_q;
  assign o_timeout        = timeout_q;
  assign o_tx_count       = tx_cnt_q;
  assign o_rx_count       = rx_cnt_q;
  assign o_err_count      = err_cnt_q;
  assign o_first_err_data = first_err_q;

endmodule
